// File: rtl/load_store_issue.sv
// Load/store issue stage: latches one request from execute, pulses it to memory_control_fsm,
// then returns load data or store completion. `define LSU_TIMEOUT_EN adds a WAIT-cycle abort.
module load_store_issue #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [1:0]        ex_word_type,
  input  logic              ex_signed,
  input  logic [ADDR_W-1:0] ex_address,
  input  logic [31:0]       ex_store_data,
  input  logic [3:0]        ex_rd,
  output logic              mem_load,
  output logic              mem_store,
  output logic [1:0]        mem_word_type,
  output logic              mem_is_signed,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  input  logic              mem_busy,
  input  logic              mem_output_valid,
  input  logic [31:0]       mem_data_out,
  output logic              wb_valid,
  output logic [3:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              store_done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state, state_nx;
  logic   op_load;
  logic   accept, bad_req, finish, timeout;

  assign ex_ready = (state == IDLE) && !reset;
  assign accept   = ex_ready && ex_valid && (ex_load ^ ex_store) && (ex_word_type != 2'b11);
  assign bad_req  = ex_ready && ex_valid && ((ex_load && ex_store) || (ex_word_type == 2'b11));
  // A store completes on the first WAIT cycle memory reports idle; stray output_valid is ignored.
  assign finish   = (state == WAIT) && (op_load ? mem_output_valid : !mem_busy);

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  // Abort on the TIMEOUT_CYCLES-th WAIT cycle unless the access completes in that same cycle.
  assign timeout = (state == WAIT) && !finish && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (finish) state_nx = DONE;
               else if (timeout) state_nx = IDLE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_load       <= 1'b0;
      mem_word_type <= '0;
      mem_is_signed <= 1'b0;
      mem_address   <= '0;
      mem_data_in   <= '0;
      wb_rd         <= '0;
      wb_data       <= '0;
      err           <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= bad_req || timeout;
      if (accept) begin
        op_load       <= ex_load;
        mem_word_type <= ex_word_type;
        mem_is_signed <= ex_signed;
        mem_address   <= ex_address;
        mem_data_in   <= ex_store_data;
        wb_rd         <= ex_rd;
      end
      if (state == WAIT && op_load && mem_output_valid) wb_data <= mem_data_out;
    end
  end

  // Pulses are state decodes, so each lasts exactly one cycle and is 0 out of reset.
  assign mem_load   = (state == ISSUE) && op_load;
  assign mem_store  = (state == ISSUE) && !op_load;
  assign wb_valid   = (state == DONE) && op_load;
  assign store_done = (state == DONE) && !op_load;

endmodule

// File: tb/tb_load_store_issue.sv
// Randomized bench for load_store_issue: a cycle-stepped memory responder plus a
// transaction-level expectation of latency, pulses and held attributes.
module tb_load_store_issue;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              ex_valid, ex_ready, ex_load, ex_store, ex_signed;
  logic [1:0]        ex_word_type;
  logic [ADDR_W-1:0] ex_address;
  logic [31:0]       ex_store_data;
  logic [3:0]        ex_rd;
  logic              mem_load, mem_store, mem_is_signed;
  logic [1:0]        mem_word_type;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic              mem_busy, mem_output_valid;
  logic [31:0]       mem_data_out;
  logic              wb_valid, store_done, err;
  logic [3:0]        wb_rd;
  logic [31:0]       wb_data;

  load_store_issue #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
    .ex_word_type(ex_word_type), .ex_signed(ex_signed), .ex_address(ex_address),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .mem_load(mem_load), .mem_store(mem_store), .mem_word_type(mem_word_type),
    .mem_is_signed(mem_is_signed), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_busy(mem_busy), .mem_output_valid(mem_output_valid), .mem_data_out(mem_data_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .store_done(store_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int n_ld, n_st, n_wb, n_sd, n_err, attr_bad, iss_cyc, wb_cyc, sd_cyc;
  logic [3:0]  wb_rd_s;
  logic [31:0] wb_data_s, last_ld;
  logic [15:0] iss_addr;
  bit          attr_on;
  logic [1:0]  e_wt;
  logic        e_sg;
  logic [15:0] e_addr;
  logic [31:0] e_sd;
  int          rem = 0, m_lat = 1;
  bit          m_is_ld;
  logic [31:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_log();
    n_ld = 0; n_st = 0; n_wb = 0; n_sd = 0; n_err = 0; attr_bad = 0;
    iss_cyc = -1; wb_cyc = -1; sd_cyc = -1;
  endtask

  // One clock: observe DUT just after the edge, then drive memory inputs for the next cycle.
  task automatic step();
    @(posedge clk); #1; cyc++;
    if (mem_load || mem_store) begin
      if (mem_load) n_ld++; else n_st++;
      iss_cyc = cyc; iss_addr = mem_address;
    end
    if (wb_valid) begin n_wb++; wb_cyc = cyc; wb_rd_s = wb_rd; wb_data_s = wb_data; end
    if (store_done) begin n_sd++; sd_cyc = cyc; end
    if (err) n_err++;
    if (attr_on && !ex_ready &&
        (mem_word_type !== e_wt || mem_is_signed !== e_sg ||
         mem_address !== e_addr || mem_data_in !== e_sd)) attr_bad++;
    // Memory: busy for m_lat cycles after the command; a load's data arrives on the last one.
    if (rem > 0) begin
      mem_busy = 1'b1;
      mem_output_valid = m_is_ld ? (rem == 1) : 1'($urandom_range(0, 1));
      mem_data_out = (m_is_ld && rem == 1) ? m_rdata : $urandom;
      rem--;
    end else begin
      mem_busy = 1'b0; mem_output_valid = 1'b0; mem_data_out = $urandom;
    end
    if (mem_load || mem_store) begin rem = m_lat; m_is_ld = mem_load; end
  endtask

  task automatic present(input bit ld, input bit st, input logic [1:0] wt, input bit sg,
                         input logic [15:0] addr, input logic [31:0] sd, input logic [3:0] rd);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_word_type = wt; ex_signed = sg;
    ex_address = addr; ex_store_data = sd; ex_rd = rd;
  endtask

  task automatic scramble();
    ex_valid = 1'b0; ex_load = 1'($urandom); ex_store = 1'($urandom);
    ex_word_type = 2'($urandom); ex_signed = 1'($urandom);
    ex_address = 16'($urandom); ex_store_data = $urandom; ex_rd = 4'($urandom);
  endtask

  task automatic txn(input bit ld, input bit st, input logic [1:0] wt, input bit sg,
                     input logic [15:0] addr, input logic [31:0] sd, input logic [3:0] rd,
                     input int lat);
    bit legal, bad, done;
    int e0, rdy_bad;
    legal = (ld != st) && (wt != 2'b11);
    bad   = (ld && st) || (wt == 2'b11);
    clear_log();
    e_wt = wt; e_sg = sg; e_addr = addr; e_sd = sd;
    m_lat = lat; m_rdata = $urandom; attr_on = legal;
    present(ld, st, wt, sg, addr, sd, rd);
    step(); e0 = cyc;
    scramble();
    if (!legal) begin
      chk("err_flag", err, bad);
      chk("ready_kept", ex_ready, 1);
      step();
      chk("err_once", err, 0);
      chk("no_cmd", n_ld + n_st, 0);
      chk("wb_hold_bad", wb_data, last_ld);
      return;
    end
    chk("ready_low_issue", ex_ready, 0);
    done = 0; rdy_bad = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      step();
      if (ex_ready) rdy_bad++;
      done = ld ? (n_wb > 0) : (n_sd > 0);
    end
    chk("completed", done, 1);
    chk("cmd_count", ld ? n_ld : n_st, 1);
    chk("cmd_other", ld ? n_st : n_ld, 0);
    chk("ready_held_low", rdy_bad, 0);
    chk("attr_stable", attr_bad, 0);
    if (ld) begin
      chk("wb_latency", wb_cyc - e0, lat + 1);
      chk("wb_rd", wb_rd_s, rd);
      chk("wb_data", wb_data_s, m_rdata);
      chk("no_store_done", n_sd, 0);
      last_ld = m_rdata;
    end else begin
      chk("sd_latency", sd_cyc - e0, lat + 2);
      chk("no_wb", n_wb, 0);
      chk("wb_hold", wb_data, last_ld);
    end
    step();
    chk("ready_back", ex_ready, 1);
    chk("single_pulse", n_wb + n_sd, 1);
    chk("no_err", n_err, 0);
    attr_on = 0;
  endtask

  initial begin
    int e0;
    reset = 1'b1; attr_on = 0; last_ld = '0;
    mem_busy = 1'b0; mem_output_valid = 1'b0; mem_data_out = '0;
    scramble(); clear_log();
    repeat (2) step();
    chk("rst_ready", ex_ready, 0);
    chk("rst_pulses", {mem_load, mem_store, wb_valid, store_done, err}, 0);
    chk("rst_data", wb_data | mem_data_in, 0);
    chk("rst_addr", mem_address, 0);
    reset = 1'b0; #1;
    chk("ready_after_rst", ex_ready, 1);

    // Directed cases
    txn(1, 0, 2'b10, 0, 16'h0010, 32'h0, 4'd5, 3);
    txn(0, 1, 2'b00, 0, 16'h0003, 32'h0000_00A5, 4'd0, 2);
    txn(1, 1, 2'b10, 0, 16'h0020, 32'h1234, 4'd1, 1);
    txn(1, 0, 2'b11, 1, 16'h0040, 32'h0, 4'd2, 1);
    txn(0, 0, 2'b01, 0, 16'h0050, 32'h0, 4'd3, 1);
    txn(1, 0, 2'b01, 1, 16'hFFFE, 32'h0, 4'd15, 1);

    // Reset while a load waits: abandoned, late output_valid must not produce a result.
    clear_log(); m_lat = 10; m_rdata = 32'hCAFE_F00D;
    present(1, 0, 2'b10, 0, 16'h0100, 32'h0, 4'd7);
    step(); scramble();
    repeat (2) step();
    reset = 1'b1; step(); reset = 1'b0; #1;
    chk("rst_wait_ready", ex_ready, 1);
    repeat (12) step();
    chk("rst_wait_no_wb", n_wb, 0);
    chk("rst_wait_cmds", n_ld + n_st, 1);
    chk("rst_wait_data", wb_data, 0);
    last_ld = '0;

    // Back-to-back with ex_valid held: second request issues 4 cycles after the first.
    clear_log(); m_lat = 1; m_rdata = $urandom;
    present(1, 0, 2'b10, 0, 16'h0A00, 32'h0, 4'd3);
    step(); e0 = cyc;
    present(1, 0, 2'b01, 1, 16'h0B02, 32'h0, 4'd9);
    repeat (2) step();
    chk("b2b_first_wb", wb_valid, 1);
    chk("b2b_first_rd", wb_rd, 3);
    step();
    chk("b2b_idle_ready", ex_ready, 1);
    step();
    ex_valid = 1'b0;
    chk("b2b_issue_cyc", iss_cyc - e0, 4);
    chk("b2b_issue_addr", iss_addr, 16'h0B02);
    chk("b2b_issue_wt", mem_word_type, 2'b01);
    repeat (2) step();
    chk("b2b_second_wb", wb_valid, 1);
    chk("b2b_second_rd", wb_rd, 9);
    chk("b2b_count", n_wb, 2);
    last_ld = m_rdata;
    step();

`ifdef LSU_TIMEOUT_EN
    clear_log(); m_lat = 0;
    present(1, 0, 2'b10, 0, 16'h0200, 32'h0, 4'd4);
    step(); e0 = cyc; scramble();
    repeat (8) step();
    chk("to_not_yet", err, 0);
    step();
    chk("to_err", err, 1);
    chk("to_ready", ex_ready, 1);
    repeat (3) step();
    chk("to_no_wb", n_wb, 0);
    chk("to_err_once", n_err, 1);
`endif

    // Random mix of legal, illegal and ignored requests
    for (int i = 0; i < 40; i++) begin
      int r;
      bit ld, st;
      logic [1:0] wt;
      r = $urandom_range(0, 9);
      ld = (r < 4) || (r == 8);
      st = (r >= 4 && r < 8) || (r == 8);
      wt = 2'($urandom_range(0, 3));
      if (r == 9) wt = 2'($urandom_range(0, 2));
      txn(ld, st, wt, 1'($urandom), 16'($urandom), $urandom, 4'($urandom), $urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
